hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the 5-stage MIPS pipeline, sitting beside the ID stage and driving the PC, IF/ID and ID/EX bubble controls. It replaces pairwise register-number comparison with a per-register pending-write scoreboard of latency counters. It covers configurable load and ALU latencies, branches compared in ID, multi-cycle data-memory freezes, taken-branch IF flush, a stall performance counter and a stall watchdog.

---
 rtl/hazard_scoreboard.sv | 183 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for a 5-stage MIPS pipeline, placed beside the ID stage.
// Each architectural register has a small latency counter: the number of
// cycles until its pending result can be forwarded to the ID comparator.
// A consumer in ID stalls while the counter of a source it reads is above
// the threshold for that consumer. Branches compare in ID, so their
// threshold is 0. Other instructions read their operands in EX, so they
// gain EX_SLACK cycles.
//
// Ports
//   clk, rst          pipeline clock, asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      source register numbers
//   id_uses_rs/rt     the source is actually read
//   id_is_branch      beq/bne, compared in ID
//   id_wr_en          instruction writes id_wr_reg
//   id_wr_reg         destination register
//   id_is_load        instruction is lw
//   branch_taken      ID branch resolves taken this cycle
//   mem_busy          data memory not ready; the whole pipeline freezes
//   nop               active-low bubble inject into ID/EX
//   ifidwrite         IF/ID register enable
//   pcwrite           PC register enable
//   flush2            flush ID/EX control (1 during a hazard stall)
//   flush_if          squash the instruction in IF/ID
//   stall_cnt         saturating count of hazard-stall cycles
//   hazard_err        sticky watchdog error (PC frozen too long)
//
// Handshake: there is no valid/ready pair here. An ID instruction "issues"
// in a cycle where id_valid=1, no source hazard is present and mem_busy=0.
// Only issued instructions write the scoreboard.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 2,
    parameter int ALU_LAT    = 1,
    parameter int EX_SLACK   = 1,
    parameter int PERF_W     = 16,
    parameter int WDOG_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_branch,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_is_load,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              nop,
    output logic              ifidwrite,
    output logic              pcwrite,
    output logic              flush2,
    output logic              flush_if,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              hazard_err
);

    localparam int NREG = 2 ** REG_AW;
    localparam int CW   = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    // A slack larger than the longest latency behaves the same as a slack
    // equal to it (never stalls), so clamp it to keep it in counter width.
    localparam int SLACK_CL = (EX_SLACK > LOAD_LAT) ? LOAD_LAT : EX_SLACK;

    localparam logic [CW-1:0] LOAD_V  = CW'(LOAD_LAT);
    localparam logic [CW-1:0] ALU_V   = CW'(ALU_LAT);
    localparam logic [CW-1:0] SLACK_V = CW'(SLACK_CL);

    localparam int WD_W = $clog2(WDOG_LIMIT + 2);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT + 1);

    logic [CW-1:0]     r_cnt [NREG];
    logic [PERF_W-1:0] r_stall_cnt;
    logic [WD_W-1:0]   r_wd;
    logic              r_err;

    logic [CW-1:0]     w_thr;
    logic              w_haz_rs;
    logic              w_haz_rt;
    logic              w_hstall;
    logic              w_issue;
    logic              w_sb_write;
    logic [WD_W-1:0]   w_wd_next;

    // Hazard detection reads the counters before this cycle's update, so a
    // source equal to the issuing instruction's own destination sees the
    // old value.
    always_comb begin
        w_thr    = id_is_branch ? '0 : SLACK_V;
        w_haz_rs = id_valid && id_uses_rs && (id_rs != '0) && (r_cnt[id_rs] > w_thr);
        w_haz_rt = id_valid && id_uses_rt && (id_rt != '0) && (r_cnt[id_rt] > w_thr);
        w_hstall = w_haz_rs || w_haz_rt;
        w_issue  = id_valid && !w_hstall && !mem_busy;
        w_sb_write = w_issue && id_wr_en && (id_wr_reg != '0);
    end

    // Freeze takes priority over a hazard stall: while memory is busy
    // nothing moves, so injecting a bubble would lose the ID instruction.
    always_comb begin
        nop       = 1'b1;
        ifidwrite = 1'b1;
        pcwrite   = 1'b1;
        flush2    = 1'b0;
        flush_if  = 1'b0;
        if (mem_busy) begin
            ifidwrite = 1'b0;
            pcwrite   = 1'b0;
        end else if (w_hstall) begin
            nop       = 1'b0;
            ifidwrite = 1'b0;
            pcwrite   = 1'b0;
            flush2    = 1'b1;
        end else begin
            flush_if  = id_valid && id_is_branch && branch_taken;
        end
    end

    // Scoreboard counters. Register 0 is hard-wired, so its counter stays 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            if (!mem_busy) begin
                for (int r = 1; r < NREG; r++) begin
                    if (w_sb_write && (id_wr_reg == REG_AW'(r))) begin
                        // New latency wins over both the decrement and
                        // any older pending value.
                        r_cnt[r] <= id_is_load ? LOAD_V : ALU_V;
                    end else if (r_cnt[r] != '0) begin
                        r_cnt[r] <= r_cnt[r] - 1'b1;
                    end
                end
            end
        end
    end

    // Stall performance counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hstall && !mem_busy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Watchdog: consecutive cycles with the PC held. The count saturates at
    // WDOG_LIMIT+1, which is also the value that raises the error.
    always_comb begin
        if (pcwrite) begin
            w_wd_next = '0;
        end else if (r_wd == WD_MAX) begin
            w_wd_next = WD_MAX;
        end else begin
            w_wd_next = r_wd + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd <= w_wd_next;
            if (w_wd_next == WD_MAX) begin
                r_err <= 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign hazard_err = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard with default parameters. Inputs are
// driven 1 time unit after the rising edge, combinational outputs are
// checked 1 unit later, then the bench advances to the next edge.
// Output vector checked as {nop, ifidwrite, pcwrite, flush2, flush_if}:
//   run     = 5'b11100
//   stall   = 5'b00010
//   freeze  = 5'b10000
//   taken   = 5'b11101
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_branch;
    logic        id_wr_en;
    logic [4:0]  id_wr_reg;
    logic        id_is_load;
    logic        branch_taken;
    logic        mem_busy;
    logic        nop;
    logic        ifidwrite;
    logic        pcwrite;
    logic        flush2;
    logic        flush_if;
    logic [15:0] stall_cnt;
    logic        hazard_err;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] RUN    = 5'b11100;
    localparam logic [4:0] STALL  = 5'b00010;
    localparam logic [4:0] FREEZE = 5'b10000;
    localparam logic [4:0] TAKEN  = 5'b11101;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_is_branch (id_is_branch),
        .id_wr_en     (id_wr_en),
        .id_wr_reg    (id_wr_reg),
        .id_is_load   (id_is_load),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .nop          (nop),
        .ifidwrite    (ifidwrite),
        .pcwrite      (pcwrite),
        .flush2       (flush2),
        .flush_if     (flush_if),
        .stall_cnt    (stall_cnt),
        .hazard_err   (hazard_err)
    );

    // clock block
    always #5 clk = ~clk;

    logic [4:0] outs;
    assign outs = {nop, ifidwrite, pcwrite, flush2, flush_if};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic wen, input logic [4:0] wr, input logic ld,
                       input logic tk, input logic busy);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_is_branch = br;
        id_wr_en     = wen;
        id_wr_reg    = wr;
        id_is_load   = ld;
        branch_taken = tk;
        mem_busy     = busy;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_outs", 32'(outs), 32'(RUN));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_err", 32'(hazard_err), 32'd0);
        rst = 1'b0;
        tick();

        // lw $8 ; add $9,$8,$1 -> one stall cycle
        drv(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        chk("lw8_issue", 32'(outs), 32'(RUN));
        tick();
        drv(1, 8, 1, 1, 1, 0, 1, 9, 0, 0, 0);
        chk("ld_alu_stall", 32'(outs), 32'(STALL));
        tick();
        drv(1, 8, 1, 1, 1, 0, 1, 9, 0, 0, 0);
        chk("ld_alu_go", 32'(outs), 32'(RUN));
        tick();
        chk("stall_cnt_1", 32'(stall_cnt), 32'd1);

        // beq $9,$2 right behind add $9 -> one stall cycle
        drv(1, 9, 2, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("alu_br_stall", 32'(outs), 32'(STALL));
        tick();
        drv(1, 9, 2, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("alu_br_go", 32'(outs), 32'(RUN));
        tick();
        chk("stall_cnt_2", 32'(stall_cnt), 32'd2);

        // lw $10 ; beq $10,$0 -> two stall cycles, then taken
        drv(1, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0);
        tick();
        drv(1, 10, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("ld_br_stall1", 32'(outs), 32'(STALL));
        tick();
        drv(1, 10, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("ld_br_stall2", 32'(outs), 32'(STALL));
        tick();
        drv(1, 10, 0, 1, 1, 1, 0, 0, 0, 1, 0);
        chk("br_taken_flush", 32'(outs), 32'(TAKEN));
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_once", 32'(outs), 32'(RUN));
        chk("stall_cnt_4", 32'(stall_cnt), 32'd4);

        // add $11 ; add $12,$11,$3 -> no stall
        drv(1, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        tick();
        drv(1, 11, 3, 1, 1, 0, 1, 12, 0, 0, 0);
        chk("alu_alu_nostall", 32'(outs), 32'(RUN));
        tick();

        // lw $8 ; 3 freeze cycles ; 1 hazard stall ; issue
        drv(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, 8, 1, 1, 1, 0, 1, 9, 0, 0, 1);
            chk("freeze", 32'(outs), 32'(FREEZE));
            tick();
        end
        chk("stall_cnt_frozen", 32'(stall_cnt), 32'd4);
        drv(1, 8, 1, 1, 1, 0, 1, 9, 0, 0, 0);
        chk("post_freeze_stall", 32'(outs), 32'(STALL));
        tick();
        drv(1, 8, 1, 1, 1, 0, 1, 9, 0, 0, 0);
        chk("post_freeze_go", 32'(outs), 32'(RUN));
        tick();
        chk("stall_cnt_5", 32'(stall_cnt), 32'd5);

        // lw $0 ; add using $0 -> no stall
        drv(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        tick();
        drv(1, 0, 0, 1, 1, 0, 1, 9, 0, 0, 0);
        chk("r0_src_nostall", 32'(outs), 32'(RUN));
        tick();

        // lw $8 ; consumer with rt=$8 but uses_rt=0 -> no stall
        drv(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        tick();
        drv(1, 1, 8, 1, 0, 0, 1, 9, 0, 0, 0);
        chk("rt_unused_nostall", 32'(outs), 32'(RUN));
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("stall_cnt_5b", 32'(stall_cnt), 32'd5);

        // watchdog: mem_busy for 20 cycles
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) chk("wd_below_limit", 32'(hazard_err), 32'd0);
            if (i == 16) chk("wd_rise", 32'(hazard_err), 32'd1);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wd_release_outs", 32'(outs), 32'(RUN));
        tick();
        chk("wd_sticky", 32'(hazard_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("wd_rst_clear", 32'(hazard_err), 32'd0);
        rst = 1'b0;
        tick();

        // reset in the middle of a load-use stall
        drv(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        tick();
        drv(1, 8, 1, 1, 1, 0, 1, 9, 0, 0, 0);
        chk("pre_rst_stall", 32'(outs), 32'(STALL));
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 32'(outs), 32'(RUN));
        chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_go", 32'(outs), 32'(RUN));
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("post_rst_err", 32'(hazard_err), 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
